arena_arbiter: RTL and testbench

Game-state controller for the bomberman arena. It shares the single 1-D arena between player A (keypad decode) and player B (debounced buttons), and arbitrates their move and bomb requests one per cycle. It runs each player's bomb fuse from a game tick, resolves explosions into health loss, and sequences the game through IDLE, PLAY and OVER. It sits between the input front-ends and the seven-segment/display logic in the top level.

---
 rtl/arena_arbiter.sv | 176 +++++++++++++++++
 tb/tb_arena_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/arena_arbiter.sv
// arena_arbiter: shares the 1-D arena between two players, arbitrates their moves and bombs,
// runs the bomb fuses and blasts from the game tick, and sequences IDLE -> PLAY -> OVER.
module arena_arbiter #(
    parameter int CELLS    = 10,
    parameter int FUSE     = 3,
    parameter int RADIUS   = 1,
    parameter int START_HP = 1,
    parameter int A_START  = 0,
    parameter int B_START  = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             a_req,
    input  logic             b_req,
    input  logic [1:0]       a_op,
    input  logic [1:0]       b_op,
    output logic             a_grant,
    output logic             b_grant,
    output logic [3:0]       a_pos,
    output logic [3:0]       b_pos,
    output logic [CELLS-1:0] bomb_map,
    output logic [CELLS-1:0] blast_map,
    output logic [1:0]       a_health,
    output logic [1:0]       b_health,
    output logic [1:0]       state,
    output logic [1:0]       winner
);
    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, OVER = 2'b10} stateType;

    stateType curState, nState;
    logic [3:0] aPos, bPos, aBomb, bBomb, nAPos, nBPos, nABomb, nBBomb;
    logic [2:0] aFuse, bFuse, nAFuse, nBFuse;
    logic [1:0] aHp, bHp, nAHp, nBHp, win, nWin;
    logic aLive, bLive, nALive, nBLive, aGrant, bGrant, nAGrant, nBGrant, rrA, nRr;
    logic [CELLS-1:0] blastMap, nBlast, bombMap, aMask, bMask, blastU;
    logic aElig, bElig, serveA, serveB, canMove, canBomb, aPrim, bPrim, aDet, bDet, ticking;
    logic [1:0] op;
    logic [3:0] myPos, otherPos, target;

    function automatic logic [CELLS-1:0] blastMask(input logic [3:0] c);
        logic [CELLS-1:0] m;
        for (int i = 0; i < CELLS; i++) m[i] = i >= int'(c) - RADIUS && i <= int'(c) + RADIUS;
        return m;
    endfunction

    assign bombMap  = (aLive ? CELLS'(1) << aBomb : '0) | (bLive ? CELLS'(1) << bBomb : '0);
    assign aElig    = a_req && !aGrant;
    assign bElig    = b_req && !bGrant;
    assign serveA   = curState == PLAY && aElig && (!bElig || rrA);
    assign serveB   = curState == PLAY && bElig && !serveA;
    assign op       = serveA ? a_op : b_op;
    assign myPos    = serveA ? aPos : bPos;
    assign otherPos = serveA ? bPos : aPos;
    assign target   = op[0] ? myPos + 4'd1 : myPos - 4'd1;
    assign canMove  = !op[1] && (op[0] ? myPos != 4'(CELLS - 1) : myPos != 4'd0)
                      && !(|(bombMap & (CELLS'(1) << target))) && target != otherPos;
    assign canBomb  = op == 2'b10 && !(serveA ? aLive : bLive) && !(|(bombMap & (CELLS'(1) << myPos)));
    assign ticking  = curState == PLAY && tick;

    always_comb begin
        nState  = curState;
        nAPos   = aPos;
        nBPos   = bPos;
        nABomb  = aBomb;
        nBBomb  = bBomb;
        nAFuse  = aFuse;
        nBFuse  = bFuse;
        nALive  = aLive;
        nBLive  = bLive;
        nAHp    = aHp;
        nBHp    = bHp;
        nWin    = win;
        nBlast  = blastMap;
        nAGrant = serveA;
        nBGrant = serveB;
        nRr     = serveA ? 1'b0 : serveB ? 1'b1 : rrA;
        if (serveA && canMove) nAPos = target;
        if (serveB && canMove) nBPos = target;
        if (serveA && canBomb) begin
            nALive = 1'b1;
            nABomb = aPos;
            nAFuse = 3'(FUSE);
        end
        if (serveB && canBomb) begin
            nBLive = 1'b1;
            nBBomb = bPos;
            nBFuse = 3'(FUSE);
        end
        // only bombs live before this cycle count down; a fresh placement keeps its full fuse
        aPrim = ticking && aLive && aFuse == 3'd1;
        bPrim = ticking && bLive && bFuse == 3'd1;
        if (ticking && aLive) nAFuse = aFuse - 3'd1;
        if (ticking && bLive) nBFuse = bFuse - 3'd1;
        aMask  = blastMask(nABomb);
        bMask  = blastMask(nBBomb);
        aDet   = nALive && (aPrim || (bPrim && bMask[nABomb]));
        bDet   = nBLive && (bPrim || (aPrim && aMask[nBBomb]));
        blastU = (aDet ? aMask : '0) | (bDet ? bMask : '0);
        if (aDet) nALive = 1'b0;
        if (bDet) nBLive = 1'b0;
        if (ticking) begin
            nBlast = blastU;
            if (blastU[nAPos] && aHp != 2'd0) nAHp = aHp - 2'd1;
            if (blastU[nBPos] && bHp != 2'd0) nBHp = bHp - 2'd1;
            if (nAHp == 2'd0 || nBHp == 2'd0) begin
                nState = OVER;
                nWin   = {nAHp == 2'd0, nBHp == 2'd0};
            end
        end
        if (start && curState != PLAY) begin
            nState  = PLAY;
            nAPos   = 4'(A_START);
            nBPos   = 4'(B_START);
            nALive  = 1'b0;
            nBLive  = 1'b0;
            nAFuse  = 3'd0;
            nBFuse  = 3'd0;
            nAHp    = 2'(START_HP);
            nBHp    = 2'(START_HP);
            nWin    = 2'd0;
            nBlast  = '0;
            nRr     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            curState <= IDLE;
            aPos     <= 4'(A_START);
            bPos     <= 4'(B_START);
            aBomb    <= 4'd0;
            bBomb    <= 4'd0;
            aFuse    <= 3'd0;
            bFuse    <= 3'd0;
            aLive    <= 1'b0;
            bLive    <= 1'b0;
            aHp      <= 2'(START_HP);
            bHp      <= 2'(START_HP);
            win      <= 2'd0;
            blastMap <= '0;
            aGrant   <= 1'b0;
            bGrant   <= 1'b0;
            rrA      <= 1'b1;
        end else begin
            curState <= nState;
            aPos     <= nAPos;
            bPos     <= nBPos;
            aBomb    <= nABomb;
            bBomb    <= nBBomb;
            aFuse    <= nAFuse;
            bFuse    <= nBFuse;
            aLive    <= nALive;
            bLive    <= nBLive;
            aHp      <= nAHp;
            bHp      <= nBHp;
            win      <= nWin;
            blastMap <= nBlast;
            aGrant   <= nAGrant;
            bGrant   <= nBGrant;
            rrA      <= nRr;
        end
    end

    assign a_grant   = aGrant;
    assign b_grant   = bGrant;
    assign a_pos     = aPos;
    assign b_pos     = bPos;
    assign bomb_map  = bombMap;
    assign blast_map = blastMap;
    assign a_health  = aHp;
    assign b_health  = bHp;
    assign state     = curState;
    assign winner    = win;
endmodule

// File: tb/tb_arena_arbiter.sv
// tb_arena_arbiter: directed game scenarios against hand-computed arena, health and state values.
module tb_arena_arbiter;
    logic clk = 1'b0, rst = 1'b1, tick = 1'b0, start = 1'b0;
    logic a_req = 1'b0, b_req = 1'b0;
    logic [1:0] a_op = 2'b11, b_op = 2'b11;
    logic a_grant, b_grant;
    logic [3:0] a_pos, b_pos;
    logic [9:0] bomb_map, blast_map;
    logic [1:0] a_health, b_health, state, winner;
    int checks = 0, errors = 0;

    arena_arbiter dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .a_req(a_req), .b_req(b_req), .a_op(a_op), .b_op(b_op),
        .a_grant(a_grant), .b_grant(b_grant), .a_pos(a_pos), .b_pos(b_pos),
        .bomb_map(bomb_map), .blast_map(blast_map),
        .a_health(a_health), .b_health(b_health), .state(state), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reqA(input logic [1:0] op);
        a_req = 1'b1;
        a_op = op;
        step();
        a_req = 1'b0;
        chk("a_grant_pulse", a_grant, 1);
        step();
    endtask

    task automatic reqB(input logic [1:0] op);
        b_req = 1'b1;
        b_op = op;
        step();
        b_req = 1'b0;
        chk("b_grant_pulse", b_grant, 1);
        step();
    endtask

    task automatic pulseTick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic doStart();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_pos", {a_pos, b_pos}, 8'h09);
        chk("rst_hp", {a_health, b_health}, 4'b0101);
        chk("rst_maps", {bomb_map, blast_map}, 0);
        chk("rst_winner", winner, 0);
        a_req = 1'b1;
        a_op = 2'b01;
        step();
        step();
        chk("idle_no_grant", a_grant, 0);
        chk("idle_no_move", a_pos, 0);
        a_req = 1'b0;
        doStart();
        chk("start_state", state, 1);
        chk("start_pos", {a_pos, b_pos}, 8'h09);
        // contention: A favoured first, B served the next cycle
        a_req = 1'b1; a_op = 2'b01;
        b_req = 1'b1; b_op = 2'b00;
        step();
        chk("tie_a_grant", {a_grant, b_grant}, 2'b10);
        chk("tie_a_pos", a_pos, 1);
        a_req = 1'b0;
        step();
        chk("tie_b_grant", {a_grant, b_grant}, 2'b01);
        chk("tie_b_pos", b_pos, 8);
        b_req = 1'b0;
        step();
        chk("grants_clear", {a_grant, b_grant}, 0);
        a_req = 1'b1; a_op = 2'b11;
        b_req = 1'b1; b_op = 2'b11;
        step();
        chk("tie2_a_first", {a_grant, b_grant}, 2'b10);
        a_req = 1'b0;
        step();
        chk("tie2_b_next", {a_grant, b_grant}, 2'b01);
        b_req = 1'b0;
        step();
        chk("noop_pos", {a_pos, b_pos}, 8'h18);
        // edges, bomb placement, blocking
        reqA(2'b00);
        chk("a_left_edge", a_pos, 1 - 1);
        reqA(2'b00);
        chk("a_left_edge2", a_pos, 0);
        reqA(2'b10);
        chk("bomb_at0", bomb_map, 10'h001);
        reqA(2'b01);
        chk("a_right", a_pos, 1);
        reqA(2'b00);
        chk("blocked_by_bomb", a_pos, 1);
        reqA(2'b10);
        chk("second_bomb_ignored", bomb_map, 10'h001);
        pulseTick();
        chk("fuse1_bomb", bomb_map, 10'h001);
        step();
        pulseTick();
        chk("fuse2_blast", blast_map, 0);
        step();
        pulseTick();
        chk("det_blast", blast_map, 10'h003);
        chk("det_bomb", bomb_map, 0);
        chk("det_hp", {a_health, b_health}, 4'b0001);
        chk("det_state", state, 2);
        chk("det_winner", winner, 2);
        a_req = 1'b1; a_op = 2'b01;
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        chk("over_no_grant", a_grant, 0);
        chk("over_hold", {a_pos, blast_map}, {4'd1, 10'h003});
        a_req = 1'b0;
        doStart();
        chk("restart_state", {state, winner}, 4'b0100);
        chk("restart_pos", {a_pos, b_pos}, 8'h09);
        chk("restart_hp_blast", {a_health, b_health, blast_map}, {4'b0101, 10'h000});
        // chain detonation and draw
        for (int i = 0; i < 4; i++) begin
            reqA(2'b01);
            reqB(2'b00);
        end
        chk("chain_pos", {a_pos, b_pos}, 8'h45);
        reqA(2'b01);
        chk("into_b_blocked", a_pos, 4);
        reqA(2'b10);
        pulseTick();
        reqB(2'b10);
        chk("chain_bombs", bomb_map, 10'h030);
        pulseTick();
        chk("chain_pre", {bomb_map, state}, {10'h030, 2'b01});
        pulseTick();
        chk("chain_blast", blast_map, 10'h078);
        chk("chain_bomb_clear", bomb_map, 0);
        chk("chain_hp", {a_health, b_health}, 0);
        chk("chain_over", {state, winner}, 4'b1011);
        doStart();
        // move out of range on the detonating tick
        reqA(2'b01);
        reqA(2'b10);
        reqA(2'b01);
        chk("escape_setup", {a_pos, bomb_map}, {4'd2, 10'h002});
        pulseTick();
        pulseTick();
        a_req = 1'b1; a_op = 2'b01;
        tick = 1'b1;
        step();
        a_req = 1'b0; tick = 1'b0;
        chk("escape_grant", a_grant, 1);
        chk("escape_pos", a_pos, 3);
        chk("escape_blast", blast_map, 10'h007);
        chk("escape_hp", {a_health, state}, 4'b0101);
        step();
        pulseTick();
        chk("quiet_tick_clears", blast_map, 0);
        // reset mid-fuse and mid-request
        reqA(2'b10);
        chk("bomb_at3", bomb_map, 10'h008);
        pulseTick();
        rst = 1'b1; a_req = 1'b1; a_op = 2'b00; tick = 1'b1;
        step();
        rst = 1'b0; tick = 1'b0;
        chk("rst_mid_bomb", bomb_map, 0);
        chk("rst_mid_state", state, 0);
        chk("rst_mid_grant", {a_grant, a_pos}, 5'h00);
        step();
        chk("rst_then_idle", a_grant, 0);
        a_req = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
